// File: rtl/mux_sequencial.sv
// -----------------------------------------------------------------------------
// mux_sequencial
//
// A registered 2:1 data selector. A bouncing push-button chooses the source.
// The button is synchronized and then debounced. Each press inverts the
// selection exactly once, however long the button is held. Releasing the
// button never changes the selection.
//
// Parameters
//   WIDTH            data path width in bits
//   DEBOUNCE_CYCLES  consecutive cycles a new button level must persist before
//                    it is accepted (1..65535)
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   toggleButton  push-button, active-high, asynchronous to clk, may bounce
//   dataIn1       data source selected when sel == 0 (synchronous to clk)
//   dataIn2       data source selected when sel == 1 (synchronous to clk)
//   dataOut       registered selected data, one cycle of latency
//   sel           registered current selection
// -----------------------------------------------------------------------------
module mux_sequencial #(
   parameter int WIDTH           = 9,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             toggleButton,
   input  logic [WIDTH-1:0] dataIn1,
   input  logic [WIDTH-1:0] dataIn2,
   output logic [WIDTH-1:0] dataOut,
   output logic             sel
);

   // The counter only has to reach DEBOUNCE_CYCLES-1. Keep at least one bit so
   // that DEBOUNCE_CYCLES == 1 still elaborates cleanly.
   localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_meta_r;   // first synchronizer stage, may go metastable
   logic             btn_s_r;       // synchronized button level
   logic             btn_d_r;       // debounced (accepted) button level
   logic             btn_d_q_r;     // accepted level delayed one cycle, for edge detection
   logic [CNT_W-1:0] count_r;       // consecutive mismatch counter

   logic             btn_d_nxt_s;
   logic [CNT_W-1:0] count_nxt_s;
   logic             press_s;

   // Two-flop synchronizer for the asynchronous button input
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_meta_r <= 1'b0;
         btn_s_r     <= 1'b0;
      end else begin
         sync_meta_r <= toggleButton;
         btn_s_r     <= sync_meta_r;
      end
   end

   // Debounce next-state logic. A level is accepted only after it has differed
   // from the accepted level on DEBOUNCE_CYCLES consecutive edges. Any edge on
   // which the levels agree restarts the count, which rejects bounce.
   always_comb begin
      btn_d_nxt_s = btn_d_r;
      count_nxt_s = count_r;
      if (btn_s_r == btn_d_r) begin
         count_nxt_s = '0;
      end else if (count_r == CNT_LAST) begin
         btn_d_nxt_s = btn_s_r;
         count_nxt_s = '0;
      end else begin
         count_nxt_s = count_r + CNT_W'(1);
      end
   end

   // Debounce state and delayed copy of the accepted level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_d_r   <= 1'b0;
         btn_d_q_r <= 1'b0;
         count_r   <= '0;
      end else begin
         btn_d_r   <= btn_d_nxt_s;
         btn_d_q_r <= btn_d_r;
         count_r   <= count_nxt_s;
      end
   end

   // Only a rising edge of the accepted level is a press. A held button
   // produces this for a single cycle, and a release never produces it.
   assign press_s = btn_d_r & ~btn_d_q_r;

   // Selection register and output data register. dataOut uses the selection
   // in force before the edge, so a new selection reaches dataOut one edge
   // after sel changes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel     <= 1'b0;
         dataOut <= '0;
      end else begin
         sel     <= sel ^ press_s;
         dataOut <= sel ? dataIn2 : dataIn1;
      end
   end

endmodule

// File: tb/tb_mux_sequencial.sv
// -----------------------------------------------------------------------------
// tb_mux_sequencial
//
// Bench for mux_sequencial with WIDTH=9 and DEBOUNCE_CYCLES=4. The stimulus
// drives inputs on the falling edge. On every rising edge it advances a
// behavioural model and queues the expected {sel, dataOut}. A separate monitor
// pops the queue just after each rising edge and compares it with the DUT.
// The directed sequences add explicit latency and value checks on top of that.
// -----------------------------------------------------------------------------
module tb_mux_sequencial;

   localparam int W = 9;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         toggleButton;
   logic [W-1:0] dataIn1;
   logic [W-1:0] dataIn2;
   logic [W-1:0] dataOut;
   logic         sel;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic         s;
      logic [W-1:0] d;
   } exp_t;

   exp_t sb_q[$];

   // Behavioural model state: the button delay line, the accepted level and
   // its previous value, the length of the current mismatch run, and the
   // selection.
   bit m_meta, m_s, m_acc, m_acc_prev, m_sel;
   int m_run;

   mux_sequencial #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk          (clk),
      .rst          (rst),
      .toggleButton (toggleButton),
      .dataIn1      (dataIn1),
      .dataIn2      (dataIn2),
      .dataOut      (dataOut),
      .sel          (sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_meta = 1'b0; m_s = 1'b0; m_acc = 1'b0; m_acc_prev = 1'b0; m_sel = 1'b0; m_run = 0;
   endtask

   // Advance the model by one rising edge and queue the expected outputs.
   task automatic model_edge();
      exp_t e;
      bit   new_sel;
      if (!rst) begin
         model_clear();
         e.s = 1'b0;
         e.d = '0;
      end else begin
         e.d     = m_sel ? dataIn2 : dataIn1;
         new_sel = m_sel ^ (m_acc && !m_acc_prev);
         m_acc_prev = m_acc;
         if (m_s != m_acc) begin
            m_run++;
            if (m_run == D) begin
               m_acc = m_s;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
         m_s    = m_meta;
         m_meta = toggleButton;
         m_sel  = new_sel;
         e.s    = m_sel;
      end
      sb_q.push_back(e);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // Assert reset asynchronously at a falling edge, check outputs before any
   // clock edge, hold it for a few edges, then release.
   task automatic do_reset(input int hold);
      rst = 1'b0;
      #1;
      model_clear();
      check("async_reset_sel", sel, 0);
      check("async_reset_dataOut", dataOut, 0);
      for (int i = 0; i < hold; i++) cycle();
      rst = 1'b1;
   endtask

   // Monitor: compare the DUT with the oldest expected entry after each edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_sel", sel, e.s);
            check("sb_dataOut", dataOut, e.d);
         end
      end
   end

   initial begin
      int first;
      model_clear();
      rst          = 1'b0;
      toggleButton = 1'b0;
      dataIn1      = 9'd100;
      dataIn2      = 9'd200;
      #2;
      check("reset_sel_no_clock", sel, 0);
      check("reset_dataOut_no_clock", dataOut, 0);
      @(negedge clk);
      cycle();
      cycle();
      check("reset_hold_dataOut", dataOut, 0);

      // Default path
      rst = 1'b1;
      cycle();
      check("default_dataOut_100", dataOut, 100);
      dataIn1 = 9'd55;
      cycle();
      check("default_dataOut_55", dataOut, 55);
      dataIn1 = 9'd100;
      cycle();

      // Clean press held for 20 cycles: sel rises on edge 2+4+1
      toggleButton = 1'b1;
      first = -1;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         if (sel === 1'b1 && first < 0) first = i;
      end
      check("press_latency_edges", first, 7);
      check("press_hold_sel", sel, 1);
      check("press_hold_dataOut", dataOut, 200);
      toggleButton = 1'b0;
      for (int i = 0; i < 20; i++) cycle();
      check("release_sel", sel, 1);

      // Bounce rejection from a fresh state
      do_reset(2);
      begin
         bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
         for (int i = 0; i < 6; i++) begin
            toggleButton = pat[i];
            cycle();
         end
      end
      for (int i = 0; i < 12; i++) cycle();
      check("bounce_sel", sel, 0);
      check("bounce_dataOut", dataOut, 100);

      // Two separate presses
      for (int p = 0; p < 2; p++) begin
         toggleButton = 1'b1;
         for (int i = 0; i < 10; i++) cycle();
         check("two_press_sel", sel, (p == 0) ? 1 : 0);
         check("two_press_dataOut", dataOut, (p == 0) ? 200 : 100);
         toggleButton = 1'b0;
         for (int i = 0; i < 10; i++) cycle();
      end

      // Boundary data values
      dataIn1 = 9'd511;
      dataIn2 = 9'd0;
      cycle();
      check("boundary_dataOut_511", dataOut, 511);
      toggleButton = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      check("boundary_dataOut_0", dataOut, 0);
      toggleButton = 1'b0;
      for (int i = 0; i < 10; i++) cycle();

      // Reset mid-debounce with the button held, then re-press after release
      dataIn1 = 9'd100;
      dataIn2 = 9'd200;
      toggleButton = 1'b1;
      cycle();
      cycle();
      cycle();
      do_reset(3);
      first = -1;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         if (sel === 1'b1 && first < 0) first = i;
      end
      check("reset_held_press_edges", first, 7);
      check("reset_held_dataOut", dataOut, 200);
      toggleButton = 1'b0;
      for (int i = 0; i < 8; i++) cycle();

      // Randomized button runs, data and occasional reset
      for (int seg = 0; seg < 80; seg++) begin
         int lvl;
         int len;
         lvl = $urandom_range(0, 1);
         len = $urandom_range(1, 10);
         if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 3));
         for (int i = 0; i < len; i++) begin
            toggleButton = lvl[0];
            dataIn1 = W'($urandom);
            dataIn2 = W'($urandom);
            cycle();
         end
      end

      toggleButton = 1'b0;
      cycle();
      cycle();
      check("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
